// File: rtl/bus_arbiter_pkg.sv
// Shared types for the IF/MEM memory-bus arbiter: transaction owner,
// owner-FIFO entry and arbitration lock state.
package bus_arbiter_pkg;

  typedef enum logic {
    OWNER_IBUS = 1'b0,
    OWNER_DBUS = 1'b1
  } owner_e;

  typedef struct packed {
    owner_e owner;
    logic   discard;
  } fifo_entry_t;

  typedef enum logic {
    ARB_OPEN   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/arb_owner_fifo.sv
// In-order FIFO recording who issued each outstanding bus transaction.
// A flush broadcast marks every queued instruction-fetch entry as discarded.
module arb_owner_fifo
  import bus_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic                     push,
  input  fifo_entry_t              push_entry,
  input  logic                     pop,
  input  logic                     flush_ibus,
  output fifo_entry_t              head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  fifo_entry_t   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

  // Entry storage, flush marking, wrapping pointers and occupancy count
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '{owner: OWNER_IBUS, discard: 1'b0};
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (flush_ibus && (mem[i].owner == OWNER_IBUS)) begin
          mem[i].discard <= 1'b1;
        end
      end
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Shares one memory bus between the instruction-fetch port and the data
// port: dbus priority with an ibus anti-starvation limit, a lock that holds
// the owner through bus back-pressure, and in-order response routing.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int XLEN            = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              ibus_req,
  input  logic [XLEN-1:0]   ibus_addr,
  input  logic              ibus_flush,
  output logic              ibus_ready,
  output logic              ibus_rvalid,
  output logic [XLEN-1:0]   ibus_rdata,
  input  logic              dbus_req,
  input  logic              dbus_write,
  input  logic [XLEN-1:0]   dbus_addr,
  input  logic [XLEN-1:0]   dbus_wdata,
  input  logic [XLEN/8-1:0] dbus_wstrb,
  output logic              dbus_ready,
  output logic              dbus_rvalid,
  output logic [XLEN-1:0]   dbus_rdata,
  output logic              bus_req,
  output logic              bus_write,
  output logic [XLEN-1:0]   bus_addr,
  output logic [XLEN-1:0]   bus_wdata,
  output logic [XLEN/8-1:0] bus_wstrb,
  input  logic              bus_ready,
  input  logic              bus_rvalid,
  input  logic [XLEN-1:0]   bus_rdata,
  output logic              bus_err
);

  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] MAX_CNT    = CW'(MAX_OUTSTANDING);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  arb_state_e    state;
  arb_state_e    state_next;
  owner_e        lock_owner;
  owner_e        sel_owner;
  logic          sel_valid;
  logic          handshake;
  logic          can_issue;
  logic [SW-1:0] starve_cnt;

  fifo_entry_t   push_entry;
  fifo_entry_t   fifo_head;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          fifo_pop;

  assign can_issue  = (fifo_count < MAX_CNT);
  assign push_entry = '{owner: sel_owner,
                        discard: (sel_owner == OWNER_IBUS) && ibus_flush};

  // Pick the winner, drive the shared bus and decide whether to lock
  always_comb begin
    sel_valid  = 1'b0;
    sel_owner  = OWNER_IBUS;
    bus_req    = 1'b0;
    bus_write  = 1'b0;
    bus_addr   = ibus_addr;
    bus_wdata  = '0;
    bus_wstrb  = '0;
    handshake  = 1'b0;
    ibus_ready = 1'b0;
    dbus_ready = 1'b0;
    state_next = ARB_OPEN;

    if (state == ARB_LOCKED) begin
      sel_owner = lock_owner;
      sel_valid = (lock_owner == OWNER_DBUS) ? dbus_req : ibus_req;
    end else if (ibus_req && (starve_cnt == STARVE_MAX)) begin
      sel_owner = OWNER_IBUS;
      sel_valid = 1'b1;
    end else if (dbus_req) begin
      sel_owner = OWNER_DBUS;
      sel_valid = 1'b1;
    end else if (ibus_req) begin
      sel_owner = OWNER_IBUS;
      sel_valid = 1'b1;
    end

    bus_req = rst_b && can_issue && sel_valid;
    if (sel_owner == OWNER_DBUS) begin
      bus_write = dbus_write;
      bus_addr  = dbus_addr;
      bus_wdata = dbus_wdata;
      bus_wstrb = dbus_wstrb;
    end

    handshake  = bus_req && bus_ready;
    ibus_ready = handshake && (sel_owner == OWNER_IBUS);
    dbus_ready = handshake && (sel_owner == OWNER_DBUS);

    if (bus_req && !bus_ready) begin
      state_next = ARB_LOCKED;
    end
  end

  // Lock register: remembers the owner while the bus back-pressures
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state      <= ARB_OPEN;
      lock_owner <= OWNER_IBUS;
    end else begin
      state <= state_next;
      if (state_next == ARB_LOCKED) begin
        lock_owner <= sel_owner;
      end
    end
  end

  // Count dbus wins while ibus waits; an ibus win or an idle ibus clears it
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      starve_cnt <= '0;
    end else if (!ibus_req || ibus_ready) begin
      starve_cnt <= '0;
    end else if (dbus_ready && (starve_cnt != STARVE_MAX)) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // A response with nothing outstanding is a protocol error that sticks
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      bus_err <= 1'b0;
    end else if (bus_rvalid && fifo_empty) begin
      bus_err <= 1'b1;
    end
  end

  assign fifo_pop    = bus_rvalid && !fifo_empty;
  assign dbus_rvalid = fifo_pop && (fifo_head.owner == OWNER_DBUS);
  assign ibus_rvalid = fifo_pop && (fifo_head.owner == OWNER_IBUS) &&
                       !fifo_head.discard && !ibus_flush;
  assign dbus_rdata  = bus_rdata;
  assign ibus_rdata  = bus_rdata;

  arb_owner_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_owner_fifo (
    .clk       (clk),
    .rst_b     (rst_b),
    .push      (handshake),
    .push_entry(push_entry),
    .pop       (fifo_pop),
    .flush_ibus(ibus_flush),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

endmodule
